vga_text_rect_fill: RTL and testbench
=====================================

# vga_text_rect_fill

Avalon-MM bus-master fill engine that sits directly upstream of the VGA text-mode VRAM/palette slave. It writes a single 16-bit cell code into every cell of a rectangle on the 80×30 text screen, using byte enables to touch only the cells inside the rectangle. The host CPU loads the rectangle and cell code through a small CSR slave and starts the fill. The engine then issues one 32-bit VRAM write per word, which frees the CPU from clearing screens and drawing boxes.

## Interface
Parameters:
- COLS, 80, text columns (cells per row); must be even.
- ROWS, 30, text rows.
- WORDS_PER_ROW, COLS/2, VRAM words per row; two 16-bit cells per word.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- AVL_CS  in  1  CSR slave chip select.
- AVL_READ  in  1  CSR read.
- AVL_WRITE  in  1  CSR write.
- AVL_ADDR  in  2  CSR word address.
- AVL_WRITEDATA  in  32  CSR write data.
- AVL_READDATA  out  32  CSR read data; combinational, zero-wait.
- M_ADDR  out  12  VRAM word address. Bit 11 is always 0, so the engine never touches the palette.
- M_WRITE  out  1  master write strobe.
- M_WRITEDATA  out  32  cell code replicated in both halves: {CODE, CODE}.
- M_BYTE_EN  out  4  byte enables; 0011 = even cell, 1100 = odd cell, 1111 = both cells.
- M_WAITREQUEST  in  1  stall; tie to 0 for the zero-wait VRAM slave.
- IRQ  out  1  level interrupt, equal to DONE & IRQ_EN.

## Operation
- CSR map:
  - 0 CTRL: bit0 START, write-1 pulse, reads 0; bit1 IRQ_EN, R/W.
  - 1 STATUS: bit0 BUSY, bit1 DONE (sticky), bit2 ERR (sticky). Any write to address 1 clears DONE and ERR.
  - 2 RECT: [6:0] X0, [14:8] X1, [20:16] Y0, [28:24] Y1. Bounds are inclusive.
  - 3 CODE: [15:0] cell code; bit15 invert, [14:8] glyph, [7:4] fg palette, [3:0] bg palette.
- Writes to RECT and CODE while BUSY are ignored. START while BUSY is ignored.
- Cell (x,y) maps to word y*WORDS_PER_ROW + (x>>1). Even x uses bits [15:0]; odd x uses bits [31:16].
- FSM states: IDLE, CHECK, WRITE, DONE.
  - IDLE: START → CHECK; BUSY is set and DONE/ERR are cleared.
  - CHECK: if X0>X1, Y0>Y1, X1≥COLS or Y1≥ROWS → ERR=1, DONE=1, BUSY=0 → IDLE, with no writes issued. Otherwise load row = Y0 and word = X0>>1 → WRITE.
  - WRITE: assert M_WRITE. The write is accepted on a cycle where M_WAITREQUEST=0. On acceptance:
    - if word < X1>>1: word+1.
    - else if row < Y1: row+1, word = X0>>1.
    - else → DONE.
  - DONE: DONE=1, BUSY=0 → IDLE (one cycle).
- Byte enables per word w:
  - low half is enabled iff 2w ≥ X0;
  - high half is enabled iff 2w+1 ≤ X1;
  - this rule also covers a single-column rectangle.
- Address arithmetic is 12-bit unsigned. The maximum address is 29*40+39 = 1199, so no wrap is possible.
- Writes are issued in raster order: row-major, left to right.

## Timing
- Reset values: AVL_READDATA=0, M_ADDR=0, M_WRITE=0, M_WRITEDATA=0, M_BYTE_EN=0, IRQ=0. All CSRs are 0 and the FSM is in IDLE.
- Master outputs are registered. M_ADDR, M_WRITEDATA and M_BYTE_EN hold stable while M_WRITE=1 and M_WAITREQUEST=1.
- START is sampled at clock edge N. CHECK occurs in cycle N+1, and the first M_WRITE is asserted in cycle N+2.
- With no stall the engine sustains one word per cycle. Total time from START to DONE is 3 + rows*words cycles.
- DONE and IRQ rise in the cycle after the last accepted write.
- A CSR write to address 1 in the same cycle as the FSM setting DONE: the set wins.
- RESET_N asserted mid-fill: M_WRITE drops immediately (asynchronous) and no further writes occur. VRAM is left partially filled.

## Test plan
- Full screen: RECT X0=0, X1=79, Y0=0, Y1=29, CODE=0x0041 → 1200 writes to addresses 0..1199, all BE=1111, data 0x00410041. DONE=1 after 1203 cycles.
- Odd edges: X0=3, X1=6, Y0=2, Y1=2 → three writes:
  - addr 81, BE=1100;
  - addr 82, BE=1111;
  - addr 83, BE=0011.
- Single cell: X0=X1=5, Y0=Y1=0 → exactly one write, addr 2, BE=1100.
- Error: X1=80 → zero writes, ERR=1, DONE=1. A write to STATUS clears both.
- Backpressure: assert M_WAITREQUEST for 3 cycles on the second write → address, data and byte enables stay stable. The total write count is unchanged, and completion is delayed by exactly 3 cycles.
- IRQ and reset: IRQ_EN=1 → IRQ is high after completion and low after a STATUS write. RESET_N asserted after the 10th write → M_WRITE drops the same cycle and all CSRs read 0.

Source files
------------

// File: rtl/vga_text_rect_fill.sv
// Avalon-MM fill engine: writes one 16-bit cell code into every cell of a
// rectangle on the text screen, one 32-bit VRAM word per accepted write.
module vga_text_rect_fill #(
  parameter int COLS          = 80,
  parameter int ROWS          = 30,
  parameter int WORDS_PER_ROW = COLS / 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [1:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  output logic [11:0] M_ADDR,
  output logic        M_WRITE,
  output logic [31:0] M_WRITEDATA,
  output logic [3:0]  M_BYTE_EN,
  input  logic        M_WAITREQUEST,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_DONE} state_t;

  localparam logic [6:0]  COLS_L = 7'(COLS);
  localparam logic [4:0]  ROWS_L = 5'(ROWS);
  localparam logic [11:0] WPR_L  = 12'(WORDS_PER_ROW);

  state_t      state_q, state_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [6:0]  x0_q, x0_d, x1_q, x1_d;
  logic [4:0]  y0_q, y0_d, y1_q, y1_d;
  logic [15:0] code_q, code_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  word_q, word_d;
  logic [11:0] m_addr_q, m_addr_d;
  logic        m_write_q, m_write_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_be_q, m_be_d;

  logic        busy;
  logic        csr_wr;
  logic        start;
  logic        rect_bad;
  logic        load_word;
  logic [5:0]  x0_word;
  logic [5:0]  x1_word;
  logic        unused_wdata;

  assign busy     = (state_q == S_CHECK) || (state_q == S_WRITE);
  assign csr_wr   = AVL_CS && AVL_WRITE;
  assign start    = csr_wr && (AVL_ADDR == 2'd0) && AVL_WRITEDATA[0] && !busy;
  assign x0_word  = x0_q[6:1];
  assign x1_word  = x1_q[6:1];
  assign rect_bad = (x0_q > x1_q) || (y0_q > y1_q) || (x1_q >= COLS_L) || (y1_q >= ROWS_L);
  assign unused_wdata = ^{AVL_WRITEDATA[31:29], AVL_WRITEDATA[23:21]};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      code_q    <= '0;
      row_q     <= '0;
      word_q    <= '0;
      m_addr_q  <= '0;
      m_write_q <= 1'b0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
    end else begin
      state_q   <= state_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      code_q    <= code_d;
      row_q     <= row_d;
      word_q    <= word_d;
      m_addr_q  <= m_addr_d;
      m_write_q <= m_write_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    err_d     = err_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    code_d    = code_q;
    row_d     = row_q;
    word_d    = word_q;
    m_addr_d  = m_addr_q;
    m_write_d = m_write_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    load_word = 1'b0;

    if (csr_wr) begin
      case (AVL_ADDR)
        2'd0: irq_en_d = AVL_WRITEDATA[1];
        2'd1: begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
        2'd2: if (!busy) begin
          x0_d = AVL_WRITEDATA[6:0];
          x1_d = AVL_WRITEDATA[14:8];
          y0_d = AVL_WRITEDATA[20:16];
          y1_d = AVL_WRITEDATA[28:24];
        end
        default: if (!busy) code_d = AVL_WRITEDATA[15:0];
      endcase
    end

    // FSM status updates come after the CSR decode so a DONE set beats a STATUS clear.
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CHECK;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_CHECK: begin
        if (rect_bad) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          row_d     = y0_q;
          word_d    = x0_word;
          m_write_d = 1'b1;
          m_wdata_d = {code_q, code_q};
          load_word = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!M_WAITREQUEST) begin
          if (word_q < x1_word) begin
            word_d    = word_q + 6'd1;
            load_word = 1'b1;
          end else if (row_q < y1_q) begin
            row_d     = row_q + 5'd1;
            word_d    = x0_word;
            load_word = 1'b1;
          end else begin
            m_write_d = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Low cell enabled when its column is at or right of X0, high cell when at or left of X1.
    if (load_word) begin
      m_addr_d = (12'(row_d) * WPR_L) + 12'(word_d);
      m_be_d   = {{2{{word_d, 1'b1} <= x1_q}}, {2{{word_d, 1'b0} >= x0_q}}};
    end
  end

  always_comb begin
    AVL_READDATA = '0;
    if (AVL_CS && AVL_READ) begin
      case (AVL_ADDR)
        2'd0:    AVL_READDATA = {30'd0, irq_en_q, 1'b0};
        2'd1:    AVL_READDATA = {29'd0, err_q, done_q, busy};
        2'd2:    AVL_READDATA = {3'd0, y1_q, 3'd0, y0_q, 1'b0, x1_q, 1'b0, x0_q};
        default: AVL_READDATA = {16'd0, code_q};
      endcase
    end
  end

  assign M_ADDR      = m_addr_q;
  assign M_WRITE     = m_write_q;
  assign M_WRITEDATA = m_wdata_q;
  assign M_BYTE_EN   = m_be_q;
  assign IRQ         = done_q && irq_en_q;

endmodule

// File: tb/tb_vga_text_rect_fill.sv
// Scoreboard bench for vga_text_rect_fill: expected VRAM writes are queued by
// the stimulus and checked by a monitor whenever the master presents a write.
module tb_vga_text_rect_fill;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        AVL_CS = 1'b0;
  logic        AVL_READ = 1'b0;
  logic        AVL_WRITE = 1'b0;
  logic [1:0]  AVL_ADDR = '0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic [31:0] AVL_READDATA;
  logic [11:0] M_ADDR;
  logic        M_WRITE;
  logic [31:0] M_WRITEDATA;
  logic [3:0]  M_BYTE_EN;
  logic        M_WAITREQUEST = 1'b0;
  logic        IRQ;

  vga_text_rect_fill dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .M_ADDR(M_ADDR), .M_WRITE(M_WRITE), .M_WRITEDATA(M_WRITEDATA),
    .M_BYTE_EN(M_BYTE_EN), .M_WAITREQUEST(M_WAITREQUEST), .IRQ(IRQ)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  wr_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a stalled write must already show the pending expected word; an accepted one pops it.
  always @(negedge CLK) begin : monitor
    wr_t e;
    if (RESET_N && M_WRITE) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d be %b, expected no write", M_ADDR, M_BYTE_EN);
        if (!M_WAITREQUEST) wr_count++;
      end else if (M_WAITREQUEST) begin
        check("stall_addr", 32'(M_ADDR), 32'(exp_q[0].addr));
        check("stall_data", M_WRITEDATA, exp_q[0].data);
        check("stall_be", 32'(M_BYTE_EN), 32'(exp_q[0].be));
      end else begin
        e = exp_q.pop_front();
        wr_count++;
        $display("[TB] write %0d addr=%0d be=%b data=%08h", wr_count, M_ADDR, M_BYTE_EN, M_WRITEDATA);
        check("write_addr", 32'(M_ADDR), 32'(e.addr));
        check("write_data", M_WRITEDATA, e.data);
        check("write_be", 32'(M_BYTE_EN), 32'(e.be));
      end
    end
  end

  function automatic logic [31:0] rect(input int x0, input int x1, input int y0, input int y1);
    return {3'd0, 5'(y1), 3'd0, 5'(y0), 1'b0, 7'(x1), 1'b0, 7'(x0)};
  endfunction

  task automatic push(input int addr, input logic [3:0] be, input logic [15:0] code);
    wr_t e;
    e.addr = 12'(addr);
    e.data = {code, code};
    e.be   = be;
    exp_q.push_back(e);
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
    @(posedge CLK);
    #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    #1;
    d = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic setup(input logic [31:0] r, input logic [15:0] c);
    csr_write(2'd2, r);
    csr_write(2'd3, {16'd0, c});
  endtask

  // Starts a fill and waits for DONE. k = words expected; stall = wait cycles on the second write;
  // poke = attempt a RECT write mid-fill; err = rectangle expected to be rejected.
  task automatic run_fill(input int k, input int stall, input bit irq_en, input bit poke, input bit err);
    logic [31:0] st;
    int cyc;
    st = '0;
    csr_write(2'd0, {30'd0, irq_en, 1'b1});
    check("check_cycle_no_write", 32'(M_WRITE), 32'd0);
    for (cyc = 1; cyc <= 5000; cyc++) begin
      @(posedge CLK);
      #1;
      if (cyc == 1) check("first_write_cycle", 32'(M_WRITE), err ? 32'd0 : 32'd1);
      if (stall > 0 && cyc == 2) M_WAITREQUEST = 1'b1;
      if (stall > 0 && cyc == 2 + stall) M_WAITREQUEST = 1'b0;
      if (poke && cyc == 10) begin
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 2'd2; AVL_WRITEDATA = 32'h0;
      end else begin
        if (poke && cyc == 11) begin
          AVL_CS = 1'b0; AVL_WRITE = 1'b0;
        end
        csr_read(2'd1, st);
        if (st[1]) break;
      end
    end
    // cyc counts edges after START was sampled; START cycle and DONE cycle add two more.
    check("start_to_done_cycles", 32'(cyc + 2), 32'(3 + k + stall));
    check("status_at_done", st, err ? 32'h6 : 32'h2);
    check("irq_at_done", 32'(IRQ), 32'(irq_en));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] bad_rects [4];
    int base;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d);
      check("reset_csr", d, 32'd0);
    end
    check("reset_m_write", 32'(M_WRITE), 32'd0);
    check("reset_m_addr", 32'(M_ADDR), 32'd0);
    check("reset_m_wdata", M_WRITEDATA, 32'd0);
    check("reset_m_be", 32'(M_BYTE_EN), 32'd0);
    check("reset_irq", 32'(IRQ), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Full screen, with an ignored RECT write while busy
    for (int r = 0; r < 30; r++)
      for (int w = 0; w < 40; w++)
        push(r * 40 + w, 4'b1111, 16'h0041);
    setup(rect(0, 79, 0, 29), 16'h0041);
    run_fill(1200, 0, 1'b0, 1'b1, 1'b0);
    csr_read(2'd2, d);
    check("rect_hold_while_busy", d, rect(0, 79, 0, 29));
    csr_write(2'd1, 32'd0);

    // Odd edges
    push(81, 4'b1100, 16'h8F21);
    push(82, 4'b1111, 16'h8F21);
    push(83, 4'b0011, 16'h8F21);
    setup(rect(3, 6, 2, 2), 16'h8F21);
    run_fill(3, 0, 1'b0, 1'b0, 1'b0);

    // Single cell with interrupt
    push(2, 4'b1100, 16'h0720);
    setup(rect(5, 5, 0, 0), 16'h0720);
    run_fill(1, 0, 1'b1, 1'b0, 1'b0);
    csr_write(2'd1, 32'd0);
    check("irq_after_status_write", 32'(IRQ), 32'd0);
    csr_read(2'd0, d);
    check("ctrl_readback", d, 32'h2);
    csr_read(2'd1, d);
    check("status_cleared", d, 32'h0);
    csr_write(2'd0, 32'd0);

    // Rejected rectangles: no writes, ERR and DONE, cleared by a STATUS write
    bad_rects[0] = rect(0, 80, 0, 0);
    bad_rects[1] = rect(10, 9, 0, 0);
    bad_rects[2] = rect(0, 1, 0, 30);
    bad_rects[3] = rect(0, 1, 5, 4);
    for (int i = 0; i < 4; i++) begin
      setup(bad_rects[i], 16'h0101);
      run_fill(0, 0, 1'b0, 1'b0, 1'b1);
      csr_write(2'd1, 32'd0);
      csr_read(2'd1, d);
      check("err_cleared", d, 32'h0);
    end

    // Backpressure on the second write
    for (int w = 0; w < 4; w++) push(40 + w, 4'b1111, 16'h1F00);
    setup(rect(0, 7, 1, 1), 16'h1F00);
    run_fill(4, 3, 1'b0, 1'b0, 1'b0);

    // Reset asserted after the 10th write of a long row
    base = wr_count;
    for (int w = 0; w < 10; w++) push(120 + w, 4'b1111, 16'h1234);
    setup(rect(0, 79, 3, 3), 16'h1234);
    csr_write(2'd0, 32'h3);
    for (int i = 0; i < 200 && wr_count < base + 10; i++) begin
      @(posedge CLK);
      #1;
    end
    check("tenth_write_seen", 32'(wr_count), 32'(base + 10));
    check("write_pending_before_reset", 32'(M_WRITE), 32'd1);
    RESET_N = 1'b0;
    #1;
    check("mwrite_drops_on_reset", 32'(M_WRITE), 32'd0);
    check("maddr_on_reset", 32'(M_ADDR), 32'd0);
    check("mbe_on_reset", 32'(M_BYTE_EN), 32'd0);
    check("irq_on_reset", 32'(IRQ), 32'd0);
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d);
      check("csr_after_reset", d, 32'd0);
    end
    repeat (5) @(posedge CLK);
    #1;
    check("no_writes_after_reset", 32'(wr_count), 32'(base + 10));
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
